// File: rtl/ser_par_if.sv
// Bundle between the receive controller and the serial-to-parallel converter
// (frame control, serial input, parallel output and RX CRC strobes).
interface ser_par_if #(
  parameter int unsigned DATA_W = 44
) ();

  logic              ser_par_intl;
  logic              rx_serial_in;
  logic              rx_bit_valid;
  logic              rx_ack;
  logic [DATA_W-1:0] par_data;
  logic              par_valid;
  logic              rx_pcrc_intl;
  logic              rx_pcrc_enable;
  logic              rx_pcrc_bit;
  logic              rx_pcrc_frm_cmp;
  logic              rx_overrun;

  modport master (
    output ser_par_intl, rx_serial_in, rx_bit_valid, rx_ack,
    input  par_data, par_valid, rx_pcrc_intl, rx_pcrc_enable,
           rx_pcrc_bit, rx_pcrc_frm_cmp, rx_overrun
  );

  modport slave (
    input  ser_par_intl, rx_serial_in, rx_bit_valid, rx_ack,
    output par_data, par_valid, rx_pcrc_intl, rx_pcrc_enable,
           rx_pcrc_bit, rx_pcrc_frm_cmp, rx_overrun
  );

endinterface

// File: rtl/ser_par_conv.sv
// Serial-to-parallel frame converter with RX CRC side strobes.
// Optional sticky overrun detection is built when SER_PAR_OVERRUN_DET_EN is defined.
module ser_par_conv #(
  parameter int unsigned DATA_W = 44
) (
  input  logic      clk,
  input  logic      g_rst,
  ser_par_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_nxt;
  logic [DATA_W-1:0] shift_q, shift_nxt, shift_word;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              valid_q, valid_nxt;
  logic              intl_q, intl_nxt;
  logic              en_q, en_nxt;
  logic              bit_q, bit_nxt;
  logic              cmp_q, cmp_nxt;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (g_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      intl_q  <= 1'b1;
      en_q    <= 1'b0;
      bit_q   <= 1'b0;
      cmp_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      shift_q <= shift_nxt;
      cnt_q   <= cnt_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      intl_q  <= intl_nxt;
      en_q    <= en_nxt;
      bit_q   <= bit_nxt;
      cmp_q   <= cmp_nxt;
    end
  end

  // Next state and next output values; abort in SHIFT wins over a sampled bit
  always_comb begin
    state_nxt  = state_q;
    shift_nxt  = shift_q;
    cnt_nxt    = cnt_q;
    data_nxt   = data_q;
    valid_nxt  = valid_q;
    intl_nxt   = 1'b0;
    en_nxt     = 1'b0;
    bit_nxt    = 1'b0;
    cmp_nxt    = 1'b0;
    shift_word = {shift_q[DATA_W-2:0], bus.rx_serial_in};

    unique case (state_q)
      IDLE: begin
        intl_nxt  = 1'b1;
        data_nxt  = '0;
        valid_nxt = 1'b0;
        if (bus.ser_par_intl) begin
          state_nxt = ARM;
          intl_nxt  = 1'b0;
        end
      end

      ARM: begin
        shift_nxt = '0;
        cnt_nxt   = '0;
        state_nxt = SHIFT;
      end

      SHIFT: begin
        if (bus.ser_par_intl) begin
          state_nxt = ARM;
        end else if (bus.rx_bit_valid) begin
          shift_nxt = shift_word;
          cnt_nxt   = cnt_q + CNT_W'(1);
          en_nxt    = 1'b1;
          bit_nxt   = bus.rx_serial_in;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            data_nxt  = shift_word;
            valid_nxt = 1'b1;
            cmp_nxt   = 1'b1;
            state_nxt = DONE;
          end
        end
      end

      DONE: begin
        if (bus.rx_ack) begin
          data_nxt  = '0;
          valid_nxt = 1'b0;
          intl_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        intl_nxt  = 1'b1;
      end
    endcase
  end

`ifdef SER_PAR_OVERRUN_DET_EN
  logic ovr_q, ovr_nxt;

  // A new frame request while the previous word is still unacknowledged
  always_comb begin
    ovr_nxt = ovr_q;
    if (state_q == DONE && bus.ser_par_intl && !bus.rx_ack) begin
      ovr_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (g_rst) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_nxt;
    end
  end

  assign bus.rx_overrun = ovr_q;
`else
  assign bus.rx_overrun = 1'b0;
`endif

  assign bus.par_data        = data_q;
  assign bus.par_valid       = valid_q;
  assign bus.rx_pcrc_intl    = intl_q;
  assign bus.rx_pcrc_enable  = en_q;
  assign bus.rx_pcrc_bit     = bit_q;
  assign bus.rx_pcrc_frm_cmp = cmp_q;

endmodule

// File: tb/tb_ser_par_conv.sv
// Scoreboard bench for ser_par_conv: driver queues expected CRC bits and frames,
// a monitor pops and compares whenever the converter strobes an output.
module tb_ser_par_conv;

  localparam int unsigned DATA_W = 44;
`ifdef SER_PAR_OVERRUN_DET_EN
  localparam logic OVR_EN = 1'b1;
`else
  localparam logic OVR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic g_rst;
  always #5 clk = ~clk;

  ser_par_if #(.DATA_W(DATA_W)) bus ();

  ser_par_conv #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .g_rst (g_rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int en_count = 0;

  logic              q_bits[$];
  logic [DATA_W-1:0] q_frames[$];
  logic [DATA_W-1:0] last_frame = '0;
  logic              prev_cmp   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none t=%0t", name, $time);
  endtask

  // Monitor: consumes expected CRC bits and frames as the DUT strobes them
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.rx_pcrc_enable) begin
        en_count++;
        if (q_bits.size() == 0) fail_now("unexpected_pcrc_enable");
        else check("pcrc_bit", 64'(bus.rx_pcrc_bit), 64'(q_bits.pop_front()));
      end
      if (bus.rx_pcrc_frm_cmp) begin
        check("frm_cmp_single", 64'(prev_cmp), 64'(0));
        check("valid_with_cmp", 64'(bus.par_valid), 64'(1));
        if (q_frames.size() == 0) fail_now("unexpected_frm_cmp");
        else begin
          last_frame = q_frames.pop_front();
          check("par_data", 64'(bus.par_data), 64'(last_frame));
        end
      end else if (bus.par_valid) begin
        check("par_data_hold", 64'(bus.par_data), 64'(last_frame));
      end
      prev_cmp = bus.rx_pcrc_frm_cmp;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic quiet_inputs();
    bus.ser_par_intl = 1'b0;
    bus.rx_serial_in = 1'b0;
    bus.rx_bit_valid = 1'b0;
    bus.rx_ack       = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_par_data"},  64'(bus.par_data),        64'(0));
    check({tag, "_par_valid"}, 64'(bus.par_valid),       64'(0));
    check({tag, "_intl"},      64'(bus.rx_pcrc_intl),    64'(1));
    check({tag, "_enable"},    64'(bus.rx_pcrc_enable),  64'(0));
    check({tag, "_bit"},       64'(bus.rx_pcrc_bit),     64'(0));
    check({tag, "_frm_cmp"},   64'(bus.rx_pcrc_frm_cmp), 64'(0));
    check({tag, "_overrun"},   64'(bus.rx_overrun),      64'(0));
  endtask

  // Entered at a negedge; start request cycle then the ARM cycle (junk bits ignored)
  task automatic start_frame();
    bus.ser_par_intl = 1'b1;
    bus.rx_bit_valid = 1'b0;
    @(negedge clk);
    check("intl_low_after_start", 64'(bus.rx_pcrc_intl), 64'(0));
    bus.ser_par_intl = 1'b0;
    bus.rx_bit_valid = 1'b1;
    bus.rx_serial_in = 1'($urandom);
    @(negedge clk);
    bus.rx_bit_valid = 1'b0;
  endtask

  // gap_mode: 0 none, 1 one gap before every bit, 2 random gaps plus stray acks
  task automatic send_bits(input logic [DATA_W-1:0] word, input int nbits, input int gap_mode);
    int gaps;
    int en0;
    logic b;
    en0 = en_count;
    for (int i = 0; i < nbits; i++) begin
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        bus.rx_bit_valid = 1'b0;
        bus.rx_serial_in = 1'($urandom);
        bus.rx_ack       = (gap_mode == 2) ? 1'($urandom) : 1'b0;
        @(negedge clk);
      end
      b = word[DATA_W-1-i];
      bus.rx_bit_valid = 1'b1;
      bus.rx_serial_in = b;
      bus.rx_ack       = (gap_mode == 2) ? 1'($urandom) : 1'b0;
      q_bits.push_back(b);
      if (i == DATA_W - 1) q_frames.push_back(word);
      @(negedge clk);
    end
    bus.rx_bit_valid = 1'b0;
    bus.rx_ack       = 1'b0;
    check("pcrc_enable_count", 64'(en_count - en0), 64'(nbits));
    if (nbits == DATA_W) check("valid_after_last_bit", 64'(bus.par_valid), 64'(1));
    else                 check("no_valid_partial", 64'(bus.par_valid), 64'(0));
  endtask

  // Hold DONE for delay cycles with junk inputs, then acknowledge
  task automatic ack_frame(input int delay);
    for (int i = 0; i < delay; i++) begin
      bus.rx_bit_valid = 1'($urandom);
      bus.rx_serial_in = 1'($urandom);
      @(negedge clk);
      check("valid_held", 64'(bus.par_valid), 64'(1));
    end
    bus.rx_bit_valid = 1'b0;
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    check("valid_clear_on_ack", 64'(bus.par_valid), 64'(0));
    check("intl_idle_after_ack", 64'(bus.rx_pcrc_intl), 64'(1));
  endtask

  task automatic pulse_reset();
    quiet_inputs();
    g_rst = 1'b1;
    @(negedge clk);
    g_rst = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [63:0] w;
    w = {32'($urandom), 32'($urandom)};
    return w[DATA_W-1:0];
  endfunction

  initial begin
    logic [DATA_W-1:0] pat_a;
    logic [DATA_W-1:0] pat_one;
    pat_a   = DATA_W'(64'hA5A_5A5A_5A5A);
    pat_one = DATA_W'(1);

    // Reset overrides an active start request and stray bits
    g_rst = 1'b1;
    bus.ser_par_intl = 1'b1;
    bus.rx_bit_valid = 1'b1;
    bus.rx_serial_in = 1'b1;
    bus.rx_ack       = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    g_rst = 1'b0;
    quiet_inputs();
    @(negedge clk);
    check("idle_intl", 64'(bus.rx_pcrc_intl), 64'(1));

    // Continuous valid bits
    start_frame();
    send_bits(pat_a, DATA_W, 0);
    ack_frame(0);

    // Alternating valid: 88 SHIFT cycles
    start_frame();
    send_bits(pat_a, DATA_W, 1);
    ack_frame(1);

    // Abort after 20 bits, then a frame of value 1
    start_frame();
    send_bits(rand_word(), 20, 0);
    start_frame();
    check("no_valid_after_abort", 64'(bus.par_valid), 64'(0));
    send_bits(pat_one, DATA_W, 0);
    ack_frame(10);

    // Reset mid-frame at bit 30, then a clean frame
    start_frame();
    send_bits(rand_word(), 30, 0);
    pulse_reset();
    check_reset_vals("midreset");
    start_frame();
    send_bits(rand_word(), DATA_W, 2);
    ack_frame(3);

    // Start request in DONE without ack: ignored, overrun when enabled
    start_frame();
    send_bits(rand_word(), DATA_W, 0);
    bus.ser_par_intl = 1'b1;
    @(negedge clk);
    check("overrun_set", 64'(bus.rx_overrun), 64'(OVR_EN));
    check("done_ignores_start", 64'(bus.par_valid), 64'(1));
    bus.rx_ack = 1'b1;
    @(negedge clk);
    check("ack_start_to_idle_valid", 64'(bus.par_valid), 64'(0));
    check("ack_start_to_idle_intl", 64'(bus.rx_pcrc_intl), 64'(1));
    quiet_inputs();
    @(negedge clk);
    check("still_idle", 64'(bus.rx_pcrc_intl), 64'(1));
    check("overrun_sticky", 64'(bus.rx_overrun), 64'(OVR_EN));
    pulse_reset();
    check("overrun_cleared", 64'(bus.rx_overrun), 64'(0));

    // Start together with ack never flags overrun
    start_frame();
    send_bits(rand_word(), DATA_W, 0);
    bus.ser_par_intl = 1'b1;
    bus.rx_ack       = 1'b1;
    @(negedge clk);
    quiet_inputs();
    check("no_overrun_with_ack", 64'(bus.rx_overrun), 64'(0));
    check("idle_after_ack_start", 64'(bus.rx_pcrc_intl), 64'(1));
    @(negedge clk);

    // Randomized frames with gaps, stray acks and idle spacing
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_frame();
      send_bits(rand_word(), DATA_W, 2);
      ack_frame(int'($urandom_range(0, 4)));
    end

    repeat (3) @(negedge clk);
    check("bit_queue_empty", 64'(q_bits.size()), 64'(0));
    check("frame_queue_empty", 64'(q_frames.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
